// File: rtl/bit_scan_seq.sv
// bit_scan_seq
//   Accepts one WIDTH-bit word and emits one beat per set bit, most
//   significant first. Each beat carries the bit index, the beat number
//   within the word, and a last flag. An all-zero word still produces one
//   beat, with pos_out = WIDTH and out_last = 1.
//
// Parameters
//   WIDTH     input word width
//   POS_W     width of pos_out / out_idx; needs room for the value WIDTH,
//             so it must be at least clog2(WIDTH)+1
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  data_in holds a word to scan
//   in_ready  block can accept a word (IDLE, and not in the cycle right
//             after reset)
//   data_in   word to enumerate
//   out_valid pos_out / out_idx / out_last are valid (SCAN)
//   out_ready consumer accepts the current beat
//   pos_out   bit index of the current beat (WIDTH for an empty word)
//   out_idx   0-based beat number within the current word
//   out_last  current beat is the final beat of the word
module bit_scan_seq #(
    parameter int WIDTH = 32,
    parameter int POS_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] pos_out,
    output logic [POS_W-1:0] out_idx,
    output logic             out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] msb_onehot;
    logic [POS_W-1:0] msb_pos;
    logic [POS_W-1:0] idx_reg;
    logic             running;
    logic             rest_zero;
    logic             accept;
    logic             beat_fire;

    // Priority encoder on the working register. The loop walks upward, so
    // the highest set bit is the one that wins. With no bit set, the
    // position is WIDTH and the one-hot mask is empty.
    always_comb begin
        msb_pos    = POS_W'(WIDTH);
        msb_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (work_reg[i]) begin
                msb_pos       = POS_W'(i);
                msb_onehot    = '0;
                msb_onehot[i] = 1'b1;
            end
        end
    end

    // The current beat is the last one when nothing remains after its bit
    // is cleared. This also covers an empty word, which has a single beat.
    assign rest_zero = ((work_reg & ~msb_onehot) == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs. The beat fields are forced to zero outside
    // SCAN, so the consumer never sees stale data while out_valid is low.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        pos_out    = '0;
        out_idx    = '0;
        out_last   = 1'b0;
        accept     = 1'b0;
        beat_fire  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = running;
                accept   = in_valid && running;
                if (accept) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                out_valid = 1'b1;
                pos_out   = msb_pos;
                out_idx   = idx_reg;
                out_last  = rest_zero;
                beat_fire = out_ready;
                if (out_ready && rest_zero) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers. 'running' holds in_ready low until the first
    // clock edge after reset is released. The working register loses the
    // reported bit on each handshake. Without a handshake, nothing here
    // changes, so the beat stays stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_reg <= '0;
            idx_reg  <= '0;
            running  <= 1'b0;
        end else begin
            running <= 1'b1;
            if (accept) begin
                work_reg <= data_in;
                idx_reg  <= '0;
            end else if (beat_fire) begin
                work_reg <= work_reg & ~msb_onehot;
                idx_reg  <= idx_reg + POS_W'(1);
            end
        end
    end

endmodule
